// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package sync_fifo_pkg;

  localparam int unsigned FIFO_STD         = 0;
  localparam int unsigned FIFO_FWFT        = 1;
  localparam int unsigned DEFAULT_AE_LEVEL = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// Host-side handshake, data and status bundle of sync_fifo_gen.
interface sync_fifo_gen_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = clog2(DEPTH);

  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             sys_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised synchronous FIFO with standard or FWFT output, level flags,
// sticky error flags and synchronous clear.
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned FWFT     = FIFO_FWFT,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = DEFAULT_AE_LEVEL
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  sync_fifo_gen_if.slave fifo
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rdata, dout_q;
  logic             dout_valid_q, overflow_q, underflow_q;
  logic             full_w, empty_w, rd_acc, wr_acc;

  // Flags decode from the registered count only, never from pointer equality.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);
  assign rd_acc  = fifo.rd_en & ~empty_w;
  assign wr_acc  = fifo.wr_en & (~full_w | rd_acc);

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .sys_clk (sys_clk),
    .we      (wr_acc & ~fifo.clr),
    .waddr   (wptr),
    .wdata   (fifo.din),
    .raddr   (rptr),
    .rdata   (rdata)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (fifo.clr) begin
      wptr         <= '0;
      rptr         <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (fifo.wr_en & ~wr_acc) overflow_q  <= 1'b1;
      if (fifo.rd_en & ~rd_acc) underflow_q <= 1'b1;
      if (FWFT == FIFO_STD) begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= rdata;
      end
    end
  end

  // FWFT presents the head word directly; standard mode presents the popped register.
  assign fifo.dout         = (FWFT == FIFO_FWFT) ? rdata : dout_q;
  assign fifo.dout_valid   = (FWFT == FIFO_FWFT) ? ~empty_w : dout_valid_q;
  assign fifo.full         = full_w;
  assign fifo.empty        = empty_w;
  assign fifo.almost_full  = (count_q >= AF_CNT);
  assign fifo.almost_empty = (count_q <= AE_CNT);
  assign fifo.count        = count_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_gen.md
Name: sync_fifo_gen

Overview:
- Parametrised synchronous FIFO, next generation of the team's 8-bit byte FIFO used between the IIC/EEPROM controller and its host-side logic.
- Generalised data width and depth; run-time-fixed choice of standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Adds fill-level count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous clear.
- Single clock domain; drop-in replacement for existing byte FIFO instances with WIDTH=8, DEPTH=32, FWFT=1.

Parameters:
- WIDTH, 8, data word width in bits (1..64).
- DEPTH, 32, number of storage words; power of two, 4..256.
- FWFT, 1, 1 = first-word-fall-through output; 0 = standard registered read.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- sys_clk  in  1  clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, priority over rd_en/wr_en.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  WIDTH  read data.
- dout_valid  out  1  FWFT=0: dout updated this cycle; FWFT=1: equals ~empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  words stored, AW = clog2(DEPTH).
- overflow  out  1  sticky: write dropped.
- underflow  out  1  sticky: read of empty FIFO.

Behaviour:
- Reset (async) and clr (sync): pointers, count, dout, dout_valid, overflow and underflow go to 0; empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared. clr drops any same-cycle rd_en/wr_en.
- Pointers: AW-bit read and write pointers plus an explicit count register. Pointers wrap DEPTH-1 -> 0 naturally. full and empty are decoded from count only, never from pointer equality.
- Write accepted (wr_acc) = wr_en & (~full | rd_acc); data goes to mem[wptr], wptr+1.
- Read accepted (rd_acc) = rd_en & ~empty; rptr+1.
- count next = count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Full + rd_en + wr_en: both accepted, count stays DEPTH.
- Empty + rd_en + wr_en: write accepted, read rejected, underflow set.
- overflow set on wr_en & ~wr_acc; underflow set on rd_en & ~rd_acc. Both hold until reset or clr.
- FWFT=0: on rd_acc, dout <= mem[rptr] at the edge and dout_valid=1 for exactly the following cycle. Otherwise dout holds and dout_valid=0. Latency is 1 cycle.
- FWFT=1: dout = mem[rptr] combinationally whenever empty=0. A write into an empty FIFO is visible on dout with empty=0 in the cycle after the write edge. rd_acc pops, and the next word appears in the following cycle. dout is don't-care while empty (value held, not checked).
- Flags and count are all registered or decoded from registered count; no combinational path from wr_en/rd_en to any flag.

Decomposition:
- Package sync_fifo_pkg: clog2 function, FIFO mode constants (FIFO_STD=0, FIFO_FWFT=1), default levels.
- Sub-module sync_fifo_mem: simple dual-port array (one write port, one asynchronous read port) parametrised by WIDTH and DEPTH.
- Pointers, count, flags and output mode stay in sync_fifo_gen.

Test Plan:
- WIDTH=8, DEPTH=32, FWFT=1: write 0x00..0x1F -> full=1, count=32, almost_full from count 30. A 33rd write -> overflow=1, count stays 32. Read all -> dout sequence 0x00..0x1F, empty=1 after the last pop.
- FWFT=0: write 0xA5 then rd_en -> dout=0xA5 with dout_valid=1 exactly one cycle after rd_en. A rd_en while empty -> underflow=1, dout holds 0xA5.
- Full FIFO, rd_en and wr_en together for 10 cycles -> count=32 every cycle, no overflow, output order preserved across pointer wrap.
- Empty FWFT FIFO, rd_en and wr_en same cycle with din=0x3C -> count=1, underflow=1, next cycle dout=0x3C and empty=0.
- Mid-stream (count=17, overflow=1), assert clr with wr_en=1 -> next cycle count=0, empty=1, overflow=0, write discarded. Repeat with sys_rst_n pulsed asynchronously between clock edges -> same values immediately.
- WIDTH=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: push 0x1234, 0xBEEF, 0x0001 -> almost_full=1, almost_empty=0. Pop two words -> almost_empty=1, dout=0x0001.
